button_mode_ctrl: RTL and testbench



---
 rtl/button_mode_ctrl.sv | 146 ++++++++++++++
 tb/tb_button_mode_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_mode_ctrl.sv
// Two-button up/down mode selector: per-button 2-flop sync, debounce FSM, optional hold-to-repeat.
// step_* rise DEBOUNCE_CYCLES+2 edges after a steady press; mode/mode_changed one edge later; no backpressure.
module button_mode_ctrl #(
  parameter int NUM_MODES       = 3,
  parameter int INIT_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 50000000,
  parameter int WRAP            = 1,
  parameter int MODE_W          = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              step_next,
  output logic              step_prev
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]  DEB_END   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  DLY_END   = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]  PER_END   = CNT_W'(REPEAT_PERIOD);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] RST_MODE  = MODE_W'(INIT_MODE);

  typedef enum logic [1:0] {IDLE, WAIT_STABLE, HELD, REPEAT} state_t;

  logic [1:0] btn_raw;
  logic [1:0] step_vec;

  assign btn_raw   = {btn_prev, btn_next};
  assign step_next = step_vec[0];
  assign step_prev = step_vec[1];

  for (genvar b = 0; b < 2; b++) begin : g_btn
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             meta, s, step_r, step_nxt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        meta   <= 1'b0;
        s      <= 1'b0;
        state  <= IDLE;
        cnt    <= '0;
        step_r <= 1'b0;
      end else begin
        meta   <= btn_raw[b];
        s      <= meta;
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        step_r <= step_nxt;
      end
    end

    // One counter serves debounce, repeat delay and repeat period; each terminal compare clears it.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step_nxt  = 1'b0;
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (s) begin
            state_nxt = WAIT_STABLE;
            cnt_nxt   = CNT_W'(1);
          end
        end
        WAIT_STABLE: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DEB_END) begin
            step_nxt  = 1'b1;
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (REPEAT_DELAY != 0) begin
            if (cnt == DLY_END) begin
              step_nxt  = 1'b1;
              state_nxt = REPEAT;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == PER_END) begin
            step_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign step_vec[b] = step_r;
  end

  logic [MODE_W-1:0] mode_nxt;

  // Opposing steps in the same cycle cancel.
  always_comb begin
    mode_nxt = mode;
    if (step_next && !step_prev) begin
      if (mode == LAST_MODE) mode_nxt = (WRAP != 0) ? '0 : mode;
      else                   mode_nxt = mode + MODE_W'(1);
    end else if (step_prev && !step_next) begin
      if (mode == '0) mode_nxt = (WRAP != 0) ? LAST_MODE : mode;
      else            mode_nxt = mode - MODE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode         <= RST_MODE;
      mode_changed <= 1'b0;
    end else begin
      mode         <= mode_nxt;
      mode_changed <= (mode_nxt != mode);
    end
  end

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Bench for button_mode_ctrl: three configurations (wrap, saturate, auto-repeat) share clock and reset;
// expected output events are queued with their edge number and matched as the DUTs strobe.
`timescale 1ns/1ps
module tb_button_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] bn, bp, sn, sp, mc;
  logic [1:0] md [3];

  always #5 clk = ~clk;

  button_mode_ctrl #(.NUM_MODES(3), .INIT_MODE(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
                     .REPEAT_PERIOD(5), .WRAP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[0]), .btn_prev(bp[0]), .mode(md[0]),
    .mode_changed(mc[0]), .step_next(sn[0]), .step_prev(sp[0]));

  button_mode_ctrl #(.NUM_MODES(3), .INIT_MODE(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
                     .REPEAT_PERIOD(5), .WRAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[1]), .btn_prev(bp[1]), .mode(md[1]),
    .mode_changed(mc[1]), .step_next(sn[1]), .step_prev(sp[1]));

  button_mode_ctrl #(.NUM_MODES(3), .INIT_MODE(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
                     .REPEAT_PERIOD(5), .WRAP(1)) u_c (
    .clk(clk), .rst_n(rst_n), .btn_next(bn[2]), .btn_prev(bp[2]), .mode(md[2]),
    .mode_changed(mc[2]), .step_next(sn[2]), .step_prev(sp[2]));

  typedef struct {
    int         dut;
    int         cyc;
    logic [4:0] out;   // {step_next, step_prev, mode_changed, mode}
  } ev_t;

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] np;
    logic [31:0] pp;
    int          off;
    logic        s_n;
    logic        s_p;
    logic [1:0]  m_before;
    logic [1:0]  m_after;
  } vec_t;

  ev_t  sbq[$];
  ev_t  mon_ev;
  vec_t tv [12];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   e0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int c, input logic s_n, input logic s_p,
                      input logic m_c, input logic [1:0] m);
    ev_t e;
    e.dut = d;
    e.cyc = c;
    e.out = {s_n, s_p, m_c, m};
    sbq.push_back(e);
  endtask

  task automatic settle_check(input string name, input int d, input logic [1:0] exp_mode);
    bn = '0;
    bp = '0;
    repeat (14) @(negedge clk);
    chk({name, "_mode"}, 32'(md[d]), 32'(exp_mode));
    chk({name, "_drain"}, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Edge counter and output monitor: any strobe must match the head of the scoreboard.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      if (sn[d] === 1'b1 || sp[d] === 1'b1 || mc[d] === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_event: dut=%0d edge=%0d actual=%b required=none",
                   d, cyc, {sn[d], sp[d], mc[d], md[d]});
        end else begin
          mon_ev = sbq.pop_front();
          chk("event_dut", 32'(d), 32'(mon_ev.dut));
          chk("event_edge", 32'(cyc), 32'(mon_ev.cyc));
          chk("event_out", 32'({sn[d], sp[d], mc[d], md[d]}), 32'(mon_ev.out));
        end
      end
    end
  end

  initial begin
    tv[0]  = '{"a_next1",   0, 32'h000F_FFFF, 32'h0,        6, 1'b1, 1'b0, 2'd0, 2'd1};
    tv[1]  = '{"a_next2",   0, 32'h000F_FFFF, 32'h0,        6, 1'b1, 1'b0, 2'd1, 2'd2};
    tv[2]  = '{"a_wrap_up", 0, 32'h000F_FFFF, 32'h0,        6, 1'b1, 1'b0, 2'd2, 2'd0};
    tv[3]  = '{"a_bounce",  0, 32'h0000_01FB, 32'h0,        9, 1'b1, 1'b0, 2'd0, 2'd1};
    tv[4]  = '{"a_short",   0, 32'h0000_05EF, 32'h0,       -1, 1'b0, 1'b0, 2'd1, 2'd1};
    tv[5]  = '{"a_prev1",   0, 32'h0,        32'h000F_FFFF, 6, 1'b0, 1'b1, 2'd1, 2'd0};
    tv[6]  = '{"a_wrap_dn", 0, 32'h0,        32'h000F_FFFF, 6, 1'b0, 1'b1, 2'd0, 2'd2};
    tv[7]  = '{"a_both",    0, 32'h000F_FFFF, 32'h000F_FFFF, 6, 1'b1, 1'b1, 2'd2, 2'd2};
    tv[8]  = '{"b_sat_lo",  1, 32'h0,        32'h000F_FFFF, 6, 1'b0, 1'b1, 2'd0, 2'd0};
    tv[9]  = '{"b_next1",   1, 32'h000F_FFFF, 32'h0,        6, 1'b1, 1'b0, 2'd0, 2'd1};
    tv[10] = '{"b_next2",   1, 32'h000F_FFFF, 32'h0,        6, 1'b1, 1'b0, 2'd1, 2'd2};
    tv[11] = '{"b_sat_hi",  1, 32'h000F_FFFF, 32'h0,        6, 1'b1, 1'b0, 2'd2, 2'd2};

    // Reset held with both buttons of DUT A pressed: no strobes, then a clean re-qualification.
    rst_n = 1'b0;
    bn    = 3'b001;
    bp    = 3'b001;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 32'({sn[0], sp[0], mc[0], md[0]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e0    = cyc + 1;
    push(0, e0 + 6, 1'b1, 1'b1, 1'b0, 2'd0);
    repeat (12) @(negedge clk);
    settle_check("reset_release", 0, 2'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e0 = cyc + 1;
      if (tv[i].off >= 0) begin
        push(tv[i].dut, e0 + tv[i].off, tv[i].s_n, tv[i].s_p, 1'b0, tv[i].m_before);
        if (tv[i].m_after != tv[i].m_before)
          push(tv[i].dut, e0 + tv[i].off + 1, 1'b0, 1'b0, 1'b1, tv[i].m_after);
      end
      for (int b = 0; b < 32; b++) begin
        bn[tv[i].dut] = tv[i].np[b];
        bp[tv[i].dut] = tv[i].pp[b];
        @(negedge clk);
      end
      settle_check(tv[i].name, tv[i].dut, tv[i].m_after);
    end

    // Reset while next is mid-qualification on DUT A: mode returns to 0, press re-qualifies from scratch.
    @(negedge clk);
    bn[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_mode", 32'(md[0]), 32'd0);
    chk("midreset_strobes", 32'({sn[0], sp[0], mc[0]}), 32'd0);
    rst_n = 1'b1;
    e0    = cyc + 1;
    push(0, e0 + 6, 1'b1, 1'b0, 1'b0, 2'd0);
    push(0, e0 + 7, 1'b0, 1'b0, 1'b1, 2'd1);
    repeat (14) @(negedge clk);
    settle_check("midreset", 0, 2'd1);

    // Auto-repeat on DUT C: next held 40 cycles.
    @(negedge clk);
    e0 = cyc + 1;
    for (int k = 0; k < 6; k++) begin
      int off;
      off = (k == 0) ? 6 : 17 + 6 * (k - 1);
      push(2, e0 + off,     1'b1, 1'b0, 1'b0, 2'(k % 3));
      push(2, e0 + off + 1, 1'b0, 1'b0, 1'b1, 2'((k + 1) % 3));
    end
    bn[2] = 1'b1;
    repeat (40) @(negedge clk);
    settle_check("repeat", 2, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
